// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree with valid/ready flow control and first/last group accumulation.
// Optional: define ADDER_TREE_PIPE_SAT_EN to clamp the accumulator instead of wrapping.
module adder_tree_pipe #(
    parameter int unsigned NINPUTS = 27,
    parameter int unsigned IWIDTH  = 8,
    parameter int unsigned OWIDTH  = 18,
    parameter int unsigned CNTW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic signed [IWIDTH-1:0] d [NINPUTS],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OWIDTH-1:0] q,
    output logic [CNTW-1:0]          out_count,
    output logic                     out_err
);

    localparam int unsigned L  = $clog2(NINPUTS);
    localparam int unsigned TW = IWIDTH + L;

    // Single global advance: the whole pipe stalls only when a result is waiting.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar l = 1; l <= int'(L); l++) begin : g_lvl
        localparam int unsigned NI = (NINPUTS + (1 << (l - 1)) - 1) >> (l - 1);
        localparam int unsigned NO = (NINPUTS + (1 << l) - 1) >> l;
        localparam int unsigned WO = IWIDTH + l;

        logic signed [WO-2:0] src [NI];
        logic signed [WO-1:0] nxt [NO];
        logic signed [WO-1:0] sum [NO];
        logic                 vld_in, fst_in, lst_in;
        logic                 vld, fst, lst;

        if (l == 1) begin : g_head
            assign vld_in = in_valid;
            assign fst_in = in_first;
            assign lst_in = in_last;
            for (genvar i = 0; i < int'(NI); i++) begin : g_src
                assign src[i] = d[i];
            end
        end else begin : g_body
            assign vld_in = g_lvl[l-1].vld;
            assign fst_in = g_lvl[l-1].fst;
            assign lst_in = g_lvl[l-1].lst;
            for (genvar i = 0; i < int'(NI); i++) begin : g_src
                assign src[i] = g_lvl[l-1].sum[i];
            end
        end

        // Pairwise add; an unpaired operand passes through sign-extended.
        for (genvar j = 0; j < int'(NO); j++) begin : g_pair
            if (2 * j + 1 < int'(NI)) begin : g_add
                assign nxt[j] = WO'(src[2*j]) + WO'(src[2*j+1]);
            end else begin : g_pass
                assign nxt[j] = WO'(src[2*j]);
            end
        end

        always_ff @(posedge clk) begin
            if (adv) begin
                sum <= nxt;
                fst <= fst_in;
                lst <= lst_in;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld <= 1'b0;
            end else if (adv) begin
                vld <= vld_in;
            end
        end
    end

    typedef enum logic {IDLE, ACC} state_t;

    state_t                     state;
    logic signed [OWIDTH-1:0]   acc;
    logic [CNTW-1:0]            cnt;

    logic                       tv, tf, tl;
    logic signed [TW-1:0]       tsum;
    logic                       start, ferr;
    logic signed [OWIDTH-1:0]   base, addend, acc_nxt;
    logic [CNTW-1:0]            cnt_nxt;

    assign tv     = g_lvl[L].vld;
    assign tf     = g_lvl[L].fst;
    assign tl     = g_lvl[L].lst;
    assign tsum   = g_lvl[L].sum[0];

    // A beat opens a fresh group when idle or when it carries first.
    assign start  = (state == IDLE) || tf;
    assign ferr   = (state == IDLE) != tf;
    assign base   = start ? '0 : acc;
    assign addend = OWIDTH'(tsum);
    assign cnt_nxt = start ? CNTW'(1) : ((&cnt) ? cnt : cnt + CNTW'(1));

`ifdef ADDER_TREE_PIPE_SAT_EN
    localparam int unsigned XW = OWIDTH + 1;
    logic signed [XW-1:0] wide;
    always_comb begin
        wide    = XW'(base) + XW'(addend);
        acc_nxt = wide[OWIDTH-1:0];
        if (wide[XW-1] != wide[XW-2]) begin
            acc_nxt = wide[XW-1] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}};
        end
    end
`else
    assign acc_nxt = base + addend;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            q         <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else if (adv) begin
            out_valid <= 1'b0;
            if (tv) begin
                if (ferr) begin
                    out_err <= 1'b1;
                end
                acc <= acc_nxt;
                cnt <= cnt_nxt;
                if (tl) begin
                    out_valid <= 1'b1;
                    q         <= acc_nxt;
                    out_count <= cnt_nxt;
                    state     <= IDLE;
                end else begin
                    state     <= ACC;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed self-checking bench for adder_tree_pipe (27 x 8-bit operands, 18-bit result).
module tb_adder_tree_pipe;

    localparam int unsigned NIN = 27;
    localparam int unsigned IW  = 8;
    localparam int unsigned OW  = 18;
    localparam int unsigned CW  = 8;

`ifdef ADDER_TREE_PIPE_SAT_EN
    localparam longint EXP40 = 131071;
`else
    localparam longint EXP40 = -124984;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_first = 1'b0;
    logic                 in_last = 1'b0;
    logic signed [IW-1:0] d [NIN];
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [OW-1:0] q;
    logic [CW-1:0]        out_count;
    logic                 out_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    longint qq [$];
    int     qc [$];
    int     qt [$];

    adder_tree_pipe #(.NINPUTS(NIN), .IWIDTH(IW), .OWIDTH(OW), .CNTW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .d(d),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .out_count(out_count), .out_err(out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed output transfer with its cycle stamp.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            qq.push_back(longint'(q));
            qc.push_back(int'(out_count));
            qt.push_back(cyc);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive_d(input int mode, input int val);
        for (int i = 0; i < int'(NIN); i++) begin
            d[i] = (mode == 0) ? IW'(val) : IW'(i - 13);
        end
    endtask

    task automatic send(input logic f, input logic l, input int mode, input int val,
                        output int acc_cyc);
        logic ok;
        int   n;
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        drive_d(mode, val);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int n);
        int k;
        k = 0;
        while (qq.size() < n && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (qq.size() < n) check("out_timeout", qq.size(), n);
    endtask

    task automatic pop(input string tag, input longint eq, input int ec);
        if (qq.size() == 0) begin
            check({tag, "_empty"}, 0, 1);
        end else begin
            check({tag, "_q"}, qq.pop_front(), eq);
            check({tag, "_cnt"}, qc.pop_front(), ec);
            void'(qt.pop_front());
        end
    endtask

    task automatic clear_q();
        qq.delete();
        qc.delete();
        qt.delete();
    endtask

    initial begin
        int a1, a2, ax, bad, k;
        drive_d(0, 0);

        // Reset state
        idle(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_err", out_err, 0);
        check("rst_q", q, 0);
        check("rst_out_count", out_count, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        idle(2);

        // Single beats back-to-back, latency and throughput
        send(1'b1, 1'b1, 0, 1, a1);
        send(1'b1, 1'b1, 0, 2, a2);
        wait_out(2);
        if (qt.size() >= 2) begin
            check("lat_single", qt[0] - (a1 - 1), 6);
            check("b2b_gap", qt[1] - qt[0], 1);
        end
        pop("ones", 27, 1);
        pop("twos", 54, 1);

        // Three-beat group, one result only
        idle(4);
        clear_q();
        send(1'b1, 1'b0, 0, 1, ax);
        send(1'b0, 1'b0, 0, 1, ax);
        send(1'b0, 1'b1, 0, 1, ax);
        idle(12);
        check("grp3_n", qq.size(), 1);
        pop("grp3", 81, 3);

        // Negative extreme and mixed-sign operands
        send(1'b1, 1'b1, 0, -128, ax);
        send(1'b1, 1'b1, 1, 0, ax);
        wait_out(2);
        pop("neg", -3456, 1);
        pop("mixed", 0, 1);

        // Backpressure: two groups queued behind a stalled output
        idle(4);
        clear_q();
        out_ready = 1'b0;
        send(1'b1, 1'b1, 0, 3, ax);
        send(1'b1, 1'b1, 0, 4, ax);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("stall_valid", out_valid, 1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || q !== 18'sd81 || out_count !== 8'd1 || in_ready !== 1'b0)
                bad++;
        end
        check("stall_stable", bad, 0);
        check("stall_no_xfer", qq.size(), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_out(2);
        pop("stall_a", 81, 1);
        pop("stall_b", 108, 1);

        // Long group: wrap or clamp at the accumulator width
        idle(4);
        clear_q();
        send(1'b1, 1'b0, 0, 127, ax);
        repeat (38) send(1'b0, 1'b0, 0, 127, ax);
        send(1'b0, 1'b1, 0, 127, ax);
        wait_out(1);
        pop("long40", EXP40, 40);

        // first in the middle of a group restarts it and flags an error
        idle(4);
        check("err_clean", out_err, 0);
        send(1'b1, 1'b0, 0, 1, ax);
        send(1'b0, 1'b0, 0, 1, ax);
        send(1'b1, 1'b1, 0, 2, ax);
        wait_out(1);
        pop("restart", 54, 1);
        check("err_set", out_err, 1);

        // Reset with a group open and a beat in flight
        idle(4);
        clear_q();
        send(1'b1, 1'b0, 0, 1, ax);
        idle(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_err", out_err, 0);
        idle(8);
        check("rst_discard", qq.size(), 0);
        send(1'b1, 1'b1, 0, 5, ax);
        wait_out(1);
        pop("post_rst", 135, 1);
        check("post_rst_err", out_err, 0);

        // Beat without first while idle still sums, but flags an error
        send(1'b0, 1'b1, 0, 1, ax);
        wait_out(1);
        pop("nofirst", 27, 1);
        check("nofirst_err", out_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
